div_unit: RTL

//  Multi-cycle iterative divider for the EXE stage; implements MIPS DIV/DIVU.
//  It is the inverse-direction partner of the EXE adder: it divides by repeated trial subtraction.
//  The EXE stage issues one operation via a valid/ready handshake.

---
 rtl/div_unit_pkg.sv | 15 +
 rtl/div_unit_if.sv | 34 +++
 rtl/div_unit_step.sv | 26 ++
 rtl/div_unit.sv | 144 ++++++++++++++
 4 files changed

// File: rtl/div_unit_pkg.sv
// div_unit shared definitions: FSM states and the divide-by-zero quotient.
// Optional early-out path: DIV_EARLY_OUT_EN.
package div_unit_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PREP,
    S_CALC,
    S_FIX,
    S_DONE
  } state_t;

  localparam logic [63:0] DIV0_QUOT = '1;

endpackage

// File: rtl/div_unit_if.sv
// div_unit request/result bundle between the EXE stage and the divider.
// master = EXE stage, slave = divider.
interface div_unit_if #(
  parameter int BUS = 32
);

  logic           div_valid_i;
  logic           div_ready_o;
  logic           div_signed_i;
  logic [BUS-1:0] dividend_i;
  logic [BUS-1:0] divisor_i;
  logic           res_valid_o;
  logic           res_ready_i;
  logic [BUS-1:0] quot_o;
  logic [BUS-1:0] rem_o;
  logic           div0_o;

  modport master (
    output div_valid_i, div_signed_i,
    output dividend_i, divisor_i,
    output res_ready_i,
    input  div_ready_o, res_valid_o,
    input  quot_o, rem_o, div0_o
  );

  modport slave (
    input  div_valid_i, div_signed_i,
    input  dividend_i, divisor_i,
    input  res_ready_i,
    output div_ready_o, res_valid_o,
    output quot_o, rem_o, div0_o
  );

endinterface

// File: rtl/div_unit_step.sv
// div_unit single restoring-division step (combinational).
// Shifts {rem,quot} left by one and trial-subtracts the divisor.
module div_unit_step #(
  parameter int BUS = 32
) (
  input  logic [BUS-1:0] rem_i,
  input  logic [BUS-1:0] quot_i,
  input  logic [BUS-1:0] dmag_i,
  output logic [BUS-1:0] rem_o,
  output logic [BUS-1:0] quot_o
);

  logic [BUS:0] sh;
  logic [BUS:0] trial;
  logic         borrow;

  // trial subtract on BUS+1 bits; msb set means borrow
  always_comb begin
    sh     = {rem_i, quot_i[BUS-1]};
    trial  = sh - {1'b0, dmag_i};
    borrow = trial[BUS];
    rem_o  = borrow ? sh[BUS-1:0] : trial[BUS-1:0];
    quot_o = {quot_i[BUS-2:0], ~borrow};
  end

endmodule

// File: rtl/div_unit.sv
// div_unit: multi-cycle restoring divider for MIPS DIV/DIVU.
// DIV_EARLY_OUT_EN skips CALC when |dividend| < |divisor| or divisor==0.
module div_unit
  import div_unit_pkg::*;
#(
  parameter int BUS   = 32,
  parameter int CNT_W = 6
) (
  input logic     clk,
  input logic     rst_n,
  input logic     flush_i,
  div_unit_if.slave bus
);

  state_t         state;
  state_t         state_n;
  logic [CNT_W-1:0] cnt;
  logic           sgn;
  logic           sign_q;
  logic           sign_r;
  logic           div0;
  logic [BUS-1:0] dvd;
  logic [BUS-1:0] dvs;
  logic [BUS-1:0] dmag;
  logic [BUS-1:0] rem;
  logic [BUS-1:0] quot;
  logic [BUS-1:0] rem_nx;
  logic [BUS-1:0] quot_nx;
  logic [BUS-1:0] a_mag;
  logic [BUS-1:0] b_mag;
  logic           take;
  logic           early;

  assign take = bus.div_valid_i & bus.div_ready_o & ~flush_i;

  // operand magnitudes from the latched raw operands
  always_comb begin
    a_mag = (sgn & dvd[BUS-1]) ? -dvd : dvd;
    b_mag = (sgn & dvs[BUS-1]) ? -dvs : dvs;
  end

`ifdef DIV_EARLY_OUT_EN
  assign early = (dvs == '0) | (a_mag < b_mag);
`else
  assign early = 1'b0;
`endif

  div_unit_step #(.BUS(BUS)) u_step (
    .rem_i  (rem),
    .quot_i (quot),
    .dmag_i (dmag),
    .rem_o  (rem_nx),
    .quot_o (quot_nx)
  );

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_n;
  end

  // next-state logic; flush wins everywhere
  always_comb begin
    state_n = state;
    if (flush_i) begin
      state_n = S_IDLE;
    end else begin
      unique case (state)
        S_IDLE: if (take) state_n = S_PREP;
        S_PREP: state_n = early ? S_FIX : S_CALC;
        S_CALC: if (cnt == CNT_W'(1)) state_n = S_FIX;
        S_FIX:  state_n = S_DONE;
        S_DONE: if (bus.res_ready_i) state_n = S_IDLE;
        default: state_n = S_IDLE;
      endcase
    end
  end

  // handshake and result outputs
  always_comb begin
    bus.div_ready_o = (state == S_IDLE);
    bus.res_valid_o = (state == S_DONE);
    bus.quot_o      = quot;
    bus.rem_o       = rem;
    bus.div0_o      = div0;
  end

  // operand latch, iteration and sign fix-up datapath
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt    <= '0;
      sgn    <= 1'b0;
      sign_q <= 1'b0;
      sign_r <= 1'b0;
      div0   <= 1'b0;
      dvd    <= '0;
      dvs    <= '0;
      dmag   <= '0;
      rem    <= '0;
      quot   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (take) begin
            sgn  <= bus.div_signed_i;
            dvd  <= bus.dividend_i;
            dvs  <= bus.divisor_i;
            div0 <= 1'b0;
          end
        end
        S_PREP: begin
          dmag   <= b_mag;
          sign_q <= sgn & (dvd[BUS-1] ^ dvs[BUS-1]);
          sign_r <= sgn & dvd[BUS-1];
          cnt    <= CNT_W'(BUS);
          if (early) begin
            quot <= '0;
            rem  <= a_mag;
          end else begin
            quot <= a_mag;
            rem  <= '0;
          end
        end
        S_CALC: begin
          rem  <= rem_nx;
          quot <= quot_nx;
          cnt  <= cnt - CNT_W'(1);
        end
        S_FIX: begin
          if (dvs == '0) begin
            quot <= DIV0_QUOT[BUS-1:0];
            rem  <= dvd;
            div0 <= 1'b1;
          end else begin
            quot <= sign_q ? -quot : quot;
            rem  <= sign_r ? -rem : rem;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
